// File: rtl/affine_pkg.sv
// rtl/affine_pkg.sv - shared types and constants for the layer-norm affine sequencer
package affine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ISSUE,
        S_HOLD1,
        S_HOLD2,
        S_DRAIN
    } state_t;

    localparam int AU_LAT    = 2;
    // Results buffered plus results in flight never exceed this, so a capture always finds room.
    localparam int OUT_DEPTH = AU_LAT;

    localparam int PRM_W     = 18;
    localparam int ALPHA_LSB = 16;
    localparam int ALPHA_W   = 2;
    localparam int GAMMA_LSB = 8;
    localparam int GAMMA_W   = 8;
    localparam int BETA_LSB  = 0;
    localparam int BETA_W    = 8;

    typedef struct packed {
        logic [ALPHA_W-1:0] alpha;
        logic [GAMMA_W-1:0] gamma;
        logic [BETA_W-1:0]  beta;
    } prm_t;

    function automatic prm_t to_prm(input logic [PRM_W-1:0] d);
        prm_t p;
        p.alpha = d[ALPHA_LSB +: ALPHA_W];
        p.gamma = d[GAMMA_LSB +: GAMMA_W];
        p.beta  = d[BETA_LSB +: BETA_W];
        return p;
    endfunction

endpackage

// File: rtl/affine_out_fifo.sv
// rtl/affine_out_fifo.sv - 2-entry output FIFO holding {last,data} words
module affine_out_fifo #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push_en;
    logic         pop_en;

    assign o_valid = (count != 2'd0);
    assign o_data  = o_valid ? mem[rd_ptr] : '0;
    assign o_count = count;
    assign pop_en  = o_valid && i_ready;
    assign push_en = i_push && (count != 2'd2);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/affine_seq_ctrl.sv
// rtl/affine_seq_ctrl.sv - per-token sequencer feeding the affine unit and collecting its results
module affine_seq_ctrl
    import affine_pkg::*;
#(
    parameter int N_CH   = 64,
    parameter int ADDR_W = $clog2(N_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic signed [21:0]       i_mean,
    input  logic        [7:0]        i_std,
    output logic                     o_busy,
    output logic                     o_done,
    input  logic                     i_x_valid,
    output logic                     o_x_ready,
    input  logic signed [8:0]        i_x_data,
    output logic                     o_prm_rd,
    output logic        [ADDR_W-1:0] o_prm_addr,
    input  logic        [PRM_W-1:0]  i_prm_data,
    output logic                     o_au_valid,
    output logic signed [8:0]        o_au_x,
    output logic        [1:0]        o_au_alpha,
    output logic signed [21:0]       o_au_mean,
    output logic        [7:0]        o_au_std,
    output logic        [7:0]        o_au_gamma,
    output logic        [7:0]        o_au_beta,
    input  logic signed [7:0]        i_au_norm,
    output logic                     o_y_valid,
    input  logic                     i_y_ready,
    output logic signed [7:0]        o_y_data,
    output logic                     o_y_last
);

    state_t              state;
    logic [ADDR_W-1:0]   ch;
    prm_t                shadow;
    logic                last_ch;
    logic                inflight;
    logic [2:0]          credit_sum;
    logic                credit_ok;
    logic                x_hs;
    logic [1:0]          fifo_count;
    logic [8:0]          fifo_dout;

    assign last_ch    = (ch == ADDR_W'(N_CH - 1));
    assign inflight   = (state == S_HOLD1) || (state == S_HOLD2);
    assign credit_sum = {1'b0, fifo_count} + {2'b00, inflight};
    assign credit_ok  = credit_sum < 3'(OUT_DEPTH);
    assign o_x_ready  = (state == S_ISSUE) && credit_ok;
    assign x_hs       = i_x_valid && o_x_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            ch         <= '0;
            shadow     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_prm_rd   <= 1'b0;
            o_prm_addr <= '0;
            o_au_valid <= 1'b0;
            o_au_x     <= '0;
            o_au_alpha <= '0;
            o_au_mean  <= '0;
            o_au_std   <= '0;
            o_au_gamma <= '0;
            o_au_beta  <= '0;
        end else begin
            o_done     <= 1'b0;
            o_au_valid <= 1'b0;
            o_prm_rd   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // o_done high means the previous token closed this very cycle; do not restart on it.
                    if (i_start && !o_done) begin
                        o_au_mean  <= i_mean;
                        o_au_std   <= i_std;
                        ch         <= '0;
                        o_busy     <= 1'b1;
                        o_prm_rd   <= 1'b1;
                        o_prm_addr <= '0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    shadow <= to_prm(i_prm_data);
                    state  <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (x_hs) begin
                        o_au_valid <= 1'b1;
                        o_au_x     <= i_x_data;
                        o_au_alpha <= shadow.alpha;
                        o_au_gamma <= shadow.gamma;
                        o_au_beta  <= shadow.beta;
                        if (!last_ch) begin
                            o_prm_rd   <= 1'b1;
                            o_prm_addr <= ch + ADDR_W'(1);
                        end
                        state <= S_HOLD1;
                    end
                end
                S_HOLD1: begin
                    state <= S_HOLD2;
                end
                S_HOLD2: begin
                    if (last_ch) begin
                        state <= S_DRAIN;
                    end else begin
                        shadow <= to_prm(i_prm_data);
                        ch     <= ch + ADDR_W'(1);
                        state  <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == 2'd0) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    affine_out_fifo #(.W(9)) u_out_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (state == S_HOLD2),
        .i_push_data ({last_ch, i_au_norm}),
        .o_valid     (o_y_valid),
        .i_ready     (i_y_ready),
        .o_data      (fifo_dout),
        .o_count     (fifo_count)
    );

    assign o_y_data = fifo_dout[7:0];
    assign o_y_last = fifo_dout[8];

endmodule

// File: tb/tb_affine_seq_ctrl.sv
// tb/tb_affine_seq_ctrl.sv - randomized self-checking bench for affine_seq_ctrl
module tb_affine_seq_ctrl;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 2;

    logic              i_clk;
    logic              i_rstn;
    logic              i_start;
    logic [21:0]       i_mean;
    logic [7:0]        i_std;
    logic              o_busy;
    logic              o_done;
    logic              i_x_valid;
    logic              o_x_ready;
    logic [8:0]        i_x_data;
    logic              o_prm_rd;
    logic [ADDR_W-1:0] o_prm_addr;
    logic [17:0]       i_prm_data;
    logic              o_au_valid;
    logic [8:0]        o_au_x;
    logic [1:0]        o_au_alpha;
    logic [21:0]       o_au_mean;
    logic [7:0]        o_au_std;
    logic [7:0]        o_au_gamma;
    logic [7:0]        o_au_beta;
    logic [7:0]        i_au_norm;
    logic              o_y_valid;
    logic              i_y_ready;
    logic [7:0]        o_y_data;
    logic              o_y_last;

    affine_seq_ctrl #(.N_CH(N_CH), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_mean(i_mean), .i_std(i_std),
        .o_busy(o_busy), .o_done(o_done), .i_x_valid(i_x_valid), .o_x_ready(o_x_ready),
        .i_x_data(i_x_data), .o_prm_rd(o_prm_rd), .o_prm_addr(o_prm_addr), .i_prm_data(i_prm_data),
        .o_au_valid(o_au_valid), .o_au_x(o_au_x), .o_au_alpha(o_au_alpha), .o_au_mean(o_au_mean),
        .o_au_std(o_au_std), .o_au_gamma(o_au_gamma), .o_au_beta(o_au_beta), .i_au_norm(i_au_norm),
        .o_y_valid(o_y_valid), .i_y_ready(i_y_ready), .o_y_data(o_y_data), .o_y_last(o_y_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [17:0] ram [N_CH];
    logic [8:0]  xv  [N_CH];
    logic [17:0] prm_q;
    logic [7:0]  au_q;

    // Stand-in affine arithmetic; only has to be a deterministic mix of every operand.
    function automatic logic [7:0] au_fn(input logic [8:0] x, input logic [1:0] a, input logic [7:0] g,
                                         input logic [7:0] b, input logic [21:0] m, input logic [7:0] s);
        logic [7:0] mm;
        mm = m[7:0] ^ m[15:8] ^ {2'b00, m[21:16]};
        return (x[7:0] ^ g) + b + {a, 6'd0} + mm + s + {7'd0, x[8]};
    endfunction

    function automatic logic [7:0] exp_y(input int c, input logic [21:0] m, input logic [7:0] s);
        logic [17:0] p;
        logic [8:0]  x;
        p = ram[c];
        x = xv[c];
        return au_fn(x, p[17:16], p[15:8], p[7:0], m, s);
    endfunction

    // Parameter RAM: registered read, garbage when not read so a mistimed latch is visible.
    always @(posedge i_clk) prm_q <= o_prm_rd ? ram[o_prm_addr] : 18'($urandom);
    assign i_prm_data = prm_q;

    // Affine unit: result valid for exactly one sample point, two edges after the issue edge.
    always @(posedge i_clk)
        au_q <= o_au_valid ? au_fn(o_au_x, o_au_alpha, o_au_gamma, o_au_beta, o_au_mean, o_au_std)
                           : 8'($urandom);
    assign i_au_norm = au_q;

    int         obs_issue[$];
    logic [7:0] obs_y[$];
    logic       obs_last[$];
    int         obs_done, obs_opnd_err, obs_mean_err, obs_misplaced, obs_first_y;
    int         obs_bp_issues, obs_bp_pops, obs_busy_after, obs_rst_done;
    logic       obs_bp_xready, obs_rst_outs, obs_timeout;

    task automatic new_data();
        for (int c = 0; c < N_CH; c++) begin
            xv[c]  = 9'($urandom);
            ram[c] = 18'($urandom);
        end
    endtask

    // Drives one token and records what the DUT did; labels count the posedge the inputs apply to.
    task automatic run_token(input logic [21:0] mean, input logic [7:0] std, input int xv_pct,
                             input int yr_pct, input int x_stall_ch, input int x_stall_len,
                             input int y_stall_len, input int mid_start_lbl, input int rst_ch,
                             input bit start_on_done);
        int   lbl, idx, au_cnt, hold_left, xstall_n, ystall_n, post, pops;
        bit   prev_hs, ystall_on, done_seen, xvalid, yready;
        logic [8:0] s_x;
        logic [1:0] s_a;
        logic [7:0] s_g, s_b;
        obs_issue.delete(); obs_y.delete(); obs_last.delete();
        obs_done = 0; obs_opnd_err = 0; obs_mean_err = 0; obs_misplaced = 0; obs_first_y = -1;
        obs_bp_issues = -1; obs_bp_pops = -1; obs_bp_xready = 1'b1; obs_busy_after = 0;
        obs_rst_done = 0; obs_rst_outs = 1'b0; obs_timeout = 1'b0;
        idx = 0; au_cnt = 0; hold_left = 0; xstall_n = 0; ystall_n = 0; post = 0; pops = 0;
        prev_hs = 0; ystall_on = 0; done_seen = 0;
        s_x = '0; s_a = '0; s_g = '0; s_b = '0;
        @(negedge i_clk);
        lbl = 0;
        i_mean = mean; i_std = std; i_start = 1'b1; i_x_valid = 1'b0; i_y_ready = 1'b1;
        while (1) begin
            @(negedge i_clk);
            lbl++;
            i_start = 1'b0;
            if (o_au_valid !== prev_hs) obs_misplaced++;
            if (o_au_valid) begin
                if (au_cnt >= N_CH) obs_opnd_err++;
                else if ({o_au_x, o_au_alpha, o_au_gamma, o_au_beta} !== {xv[au_cnt], ram[au_cnt]})
                    obs_opnd_err++;
                s_x = o_au_x; s_a = o_au_alpha; s_g = o_au_gamma; s_b = o_au_beta;
                hold_left = 2;
                au_cnt++;
            end else if (hold_left > 0) begin
                if ({o_au_x, o_au_alpha, o_au_gamma, o_au_beta} !== {s_x, s_a, s_g, s_b})
                    obs_opnd_err++;
                hold_left--;
            end
            if (o_busy && (o_au_mean !== mean || o_au_std !== std)) obs_mean_err++;
            if (rst_ch >= 0 && o_au_valid && au_cnt - 1 == rst_ch) begin
                i_rstn = 1'b0;
                #1;
                obs_rst_outs = |{o_busy, o_done, o_x_ready, o_prm_rd, o_prm_addr, o_au_valid, o_au_x,
                                 o_au_alpha, o_au_mean, o_au_std, o_au_gamma, o_au_beta, o_y_valid,
                                 o_y_data, o_y_last};
                repeat (3) begin
                    @(negedge i_clk);
                    if (o_done) obs_rst_done++;
                end
                i_rstn = 1'b1;
                break;
            end
            if (obs_first_y < 0 && o_y_valid) begin
                obs_first_y = lbl;
                ystall_on = (y_stall_len > 0);
            end
            yready = ($urandom_range(99) < yr_pct);
            if (ystall_on) begin
                yready = 1'b0;
                ystall_n++;
                if (ystall_n == y_stall_len) begin
                    obs_bp_issues = idx; obs_bp_pops = pops; obs_bp_xready = o_x_ready;
                    ystall_on = 1'b0;
                end
            end
            i_y_ready = yready;
            if (o_y_valid && yready) begin
                obs_y.push_back(o_y_data);
                obs_last.push_back(o_y_last);
                pops++;
            end
            xvalid = ($urandom_range(99) < xv_pct) && (idx < N_CH);
            if (idx == x_stall_ch && xstall_n < x_stall_len) begin
                xvalid = 1'b0;
                xstall_n++;
            end
            i_x_valid = xvalid;
            i_x_data  = (xvalid && idx < N_CH) ? xv[idx] : 9'($urandom);
            prev_hs   = xvalid && o_x_ready;
            if (prev_hs) begin
                obs_issue.push_back(lbl);
                idx++;
            end
            if (lbl == mid_start_lbl) begin
                i_start = 1'b1; i_mean = ~mean; i_std = ~std;
            end
            if (o_done) begin
                obs_done++;
                done_seen = 1'b1;
                if (start_on_done) begin
                    i_start = 1'b1; i_mean = ~mean;
                end
            end
            if (done_seen) begin
                post++;
                if (o_busy) obs_busy_after++;
                if (post == 8) break;
            end
            if (lbl > 600) begin
                obs_timeout = 1'b1;
                break;
            end
        end
        i_start = 1'b0; i_x_valid = 1'b0; i_y_ready = 1'b1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_start = 1'b0; i_mean = '0; i_std = '0;
        i_x_valid = 1'b0; i_x_data = '0; i_y_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_done, o_x_ready, o_y_valid, o_au_valid, o_prm_rd} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {o_busy, o_done, o_x_ready, o_y_valid, o_au_valid, o_prm_rd});
        end
        checks++;
        if ({o_prm_addr, o_au_x, o_au_alpha, o_au_mean, o_au_std, o_au_gamma, o_au_beta,
             o_y_data, o_y_last} !== '0) begin
            errors++;
            $display("FAIL reset_data got=nonzero want=all zero");
        end
        i_rstn = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        int want_issue [N_CH] = '{3, 6, 9, 12};
        new_data();
        run_token(22'd0, 8'h80, 100, 100, -1, 0, 0, -1, -1, 1'b0);
        checks++;
        if (obs_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got=1 want=0"); end
        checks++;
        if (obs_issue.size() != N_CH) begin
            errors++; $display("FAIL basic_issue_count got=%0d want=%0d", obs_issue.size(), N_CH);
        end
        for (int c = 0; c < obs_issue.size() && c < N_CH; c++) begin
            checks++;
            if (obs_issue[c] != want_issue[c]) begin
                errors++; $display("FAIL basic_issue_cycle ch=%0d got=%0d want=%0d", c, obs_issue[c], want_issue[c]);
            end
        end
        checks++;
        if (obs_first_y != 6) begin errors++; $display("FAIL basic_first_y got=%0d want=6", obs_first_y); end
        checks++;
        if (obs_y.size() != N_CH) begin errors++; $display("FAIL basic_y_count got=%0d want=%0d", obs_y.size(), N_CH); end
        for (int c = 0; c < obs_y.size() && c < N_CH; c++) begin
            checks++;
            if ({obs_last[c], obs_y[c]} !== {c == N_CH - 1, exp_y(c, 22'd0, 8'h80)}) begin
                errors++;
                $display("FAIL basic_y ch=%0d got=%b/%h want=%b/%h", c, obs_last[c], obs_y[c], c == N_CH - 1, exp_y(c, 22'd0, 8'h80));
            end
        end
        checks++;
        if (obs_done != 1) begin errors++; $display("FAIL basic_done got=%0d want=1", obs_done); end
        checks++;
        if (obs_opnd_err != 0) begin errors++; $display("FAIL basic_operands got=%0d bad want=0", obs_opnd_err); end
        checks++;
        if (obs_misplaced != 0) begin errors++; $display("FAIL basic_au_valid got=%0d bad want=0", obs_misplaced); end
    endtask

    task automatic test_x_stall();
        logic [21:0] m;
        logic [7:0]  s;
        m = 22'($urandom); s = 8'($urandom);
        new_data();
        run_token(m, s, 100, 100, 2, 5, 0, -1, -1, 1'b0);
        checks++;
        if (obs_issue.size() != N_CH || obs_issue[2] != 12 || obs_issue[3] != 15) begin
            errors++; $display("FAIL xstall_issue got=%0d entries want=4 with ch2@12 ch3@15", obs_issue.size());
        end
        checks++;
        if (obs_misplaced != 0) begin errors++; $display("FAIL xstall_au_valid got=%0d bad want=0", obs_misplaced); end
        checks++;
        if (obs_y.size() != N_CH) begin errors++; $display("FAIL xstall_y_count got=%0d want=%0d", obs_y.size(), N_CH); end
        for (int c = 0; c < obs_y.size() && c < N_CH; c++) begin
            checks++;
            if ({obs_last[c], obs_y[c]} !== {c == N_CH - 1, exp_y(c, m, s)}) begin
                errors++; $display("FAIL xstall_y ch=%0d got=%h want=%h", c, obs_y[c], exp_y(c, m, s));
            end
        end
        checks++;
        if (obs_done != 1) begin errors++; $display("FAIL xstall_done got=%0d want=1", obs_done); end
    endtask

    task automatic test_backpressure();
        logic [21:0] m;
        logic [7:0]  s;
        m = 22'($urandom); s = 8'($urandom);
        new_data();
        run_token(m, s, 100, 100, -1, 0, 20, -1, -1, 1'b0);
        checks++;
        if (obs_bp_issues != 2 || obs_bp_pops != 0) begin
            errors++; $display("FAIL bp_buffered got=issues %0d pops %0d want=issues 2 pops 0", obs_bp_issues, obs_bp_pops);
        end
        checks++;
        if (obs_bp_xready !== 1'b0) begin errors++; $display("FAIL bp_x_ready got=%b want=0", obs_bp_xready); end
        checks++;
        if (obs_y.size() != N_CH) begin errors++; $display("FAIL bp_y_count got=%0d want=%0d", obs_y.size(), N_CH); end
        for (int c = 0; c < obs_y.size() && c < N_CH; c++) begin
            checks++;
            if ({obs_last[c], obs_y[c]} !== {c == N_CH - 1, exp_y(c, m, s)}) begin
                errors++; $display("FAIL bp_y ch=%0d got=%h want=%h", c, obs_y[c], exp_y(c, m, s));
            end
        end
        checks++;
        if (obs_done != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", obs_done); end
    endtask

    task automatic test_mid_start();
        logic [21:0] m;
        m = 22'h1234A5;
        new_data();
        run_token(m, 8'h3C, 100, 100, -1, 0, 0, 8, -1, 1'b0);
        checks++;
        if (obs_mean_err != 0) begin errors++; $display("FAIL midstart_mean got=%0d bad cycles want=0", obs_mean_err); end
        checks++;
        if (obs_y.size() != N_CH) begin errors++; $display("FAIL midstart_y_count got=%0d want=%0d", obs_y.size(), N_CH); end
        for (int c = 0; c < obs_y.size() && c < N_CH; c++) begin
            checks++;
            if (obs_y[c] !== exp_y(c, m, 8'h3C)) begin
                errors++; $display("FAIL midstart_y ch=%0d got=%h want=%h", c, obs_y[c], exp_y(c, m, 8'h3C));
            end
        end
        checks++;
        if (obs_done != 1 || obs_busy_after != 0) begin
            errors++; $display("FAIL midstart_done got=done %0d busy_after %0d want=1 0", obs_done, obs_busy_after);
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] m;
        logic [7:0]  s;
        new_data();
        run_token(22'($urandom), 8'($urandom), 100, 100, -1, 0, 0, -1, 1, 1'b0);
        checks++;
        if (obs_rst_outs !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got=nonzero want=all zero"); end
        checks++;
        if (obs_done != 0 || obs_rst_done != 0) begin
            errors++; $display("FAIL rstmid_done got=%0d want=0", obs_done + obs_rst_done);
        end
        m = 22'($urandom); s = 8'($urandom);
        new_data();
        run_token(m, s, 100, 100, -1, 0, 0, -1, -1, 1'b0);
        checks++;
        if (obs_y.size() != N_CH || obs_done != 1) begin
            errors++; $display("FAIL rstmid_restart got=%0d outputs %0d done want=%0d 1", obs_y.size(), obs_done, N_CH);
        end
        for (int c = 0; c < obs_y.size() && c < N_CH; c++) begin
            checks++;
            if ({obs_last[c], obs_y[c]} !== {c == N_CH - 1, exp_y(c, m, s)}) begin
                errors++; $display("FAIL rstmid_y ch=%0d got=%h want=%h", c, obs_y[c], exp_y(c, m, s));
            end
        end
    endtask

    task automatic test_start_on_done();
        logic [21:0] m;
        logic [7:0]  s;
        m = 22'($urandom); s = 8'($urandom);
        new_data();
        run_token(m, s, 100, 100, -1, 0, 0, -1, -1, 1'b1);
        checks++;
        if (obs_done != 1) begin errors++; $display("FAIL startdone_done got=%0d want=1", obs_done); end
        checks++;
        if (obs_busy_after != 0) begin errors++; $display("FAIL startdone_busy got=%0d busy cycles want=0", obs_busy_after); end
    endtask

    task automatic test_random();
        logic [21:0] m;
        logic [7:0]  s;
        for (int t = 0; t < 4; t++) begin
            m = 22'($urandom); s = 8'($urandom);
            new_data();
            run_token(m, s, 30 + 20 * t, 80 - 15 * t, -1, 0, 0, -1, -1, 1'b0);
            checks++;
            if (obs_timeout !== 1'b0 || obs_done != 1) begin
                errors++; $display("FAIL rand_done tok=%0d got=%0d timeout=%b want=1", t, obs_done, obs_timeout);
            end
            checks++;
            if (obs_opnd_err != 0 || obs_misplaced != 0) begin
                errors++; $display("FAIL rand_issue tok=%0d got=%0d/%0d bad want=0/0", t, obs_opnd_err, obs_misplaced);
            end
            checks++;
            if (obs_y.size() != N_CH) begin errors++; $display("FAIL rand_y_count tok=%0d got=%0d want=%0d", t, obs_y.size(), N_CH); end
            for (int c = 0; c < obs_y.size() && c < N_CH; c++) begin
                checks++;
                if ({obs_last[c], obs_y[c]} !== {c == N_CH - 1, exp_y(c, m, s)}) begin
                    errors++; $display("FAIL rand_y tok=%0d ch=%0d got=%h want=%h", t, c, obs_y[c], exp_y(c, m, s));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x_stall();
        test_backpressure();
        test_mid_start();
        test_reset_mid();
        test_start_on_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
